// File: rtl/pong_pkg.sv
// Shared pong types and constants: paddle FSM states, playfield limits, HID keycodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        PLAY = 1'b1
    } paddle_state_t;

    // Vertical playfield limits, shared with the ball block.
    localparam logic [9:0] PF_Y_MIN = 10'd20;
    localparam logic [9:0] PF_Y_MAX = 10'd461;

    // HID usage codes.
    localparam logic [7:0] KEY_W    = 8'd26;
    localparam logic [7:0] KEY_S    = 8'd22;
    localparam logic [7:0] KEY_UP   = 8'd82;
    localparam logic [7:0] KEY_DOWN = 8'd81;

    // Increment that sticks at 15.
    function automatic logic [3:0] sat15_inc(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : v + 4'd1;
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controller bundle: player/ball-block inputs and paddle geometry outputs.
// Latency: n/a (wires only).
// Backpressure: none; outputs are level signals sampled every frame.
// Ports: keycode/serve/hit/BallY/ai_mode into the controller;
//        PaddleX/Y/L/W, moving, rally out of it.
interface paddle_ctrl_if;
    logic [7:0] keycode;
    logic       serve;
    logic       hit;
    logic [9:0] BallY;
    logic       ai_mode;
    logic [9:0] PaddleX;
    logic [9:0] PaddleY;
    logic [9:0] PaddleL;
    logic [9:0] PaddleW;
    logic       moving;
    logic [3:0] rally;

    // master: whoever drives keys and ball-block pulses (board glue / bench)
    modport master (
        output keycode, serve, hit, BallY, ai_mode,
        input  PaddleX, PaddleY, PaddleL, PaddleW, moving, rally
    );

    // slave: the paddle controller itself
    modport slave (
        input  keycode, serve, hit, BallY, ai_mode,
        output PaddleX, PaddleY, PaddleL, PaddleW, moving, rally
    );
endinterface

// File: rtl/paddle_vel_step.sv
// One frame of paddle velocity update: accelerate toward the request, else decay to 0.
// Latency: combinational.
// Backpressure: none.
// Ports: vel (current), up_req/dn_req (up wins if both), vmax (positive limit) -> vel_next.
module paddle_vel_step (
    input  logic signed [4:0] vel,
    input  logic              up_req,
    input  logic              dn_req,
    input  logic signed [4:0] vmax,
    output logic signed [4:0] vel_next
);

    always_comb begin
        vel_next = vel;
        if (up_req) begin
            if (vel <= -vmax) vel_next = -vmax;
            else              vel_next = vel - 5'sd1;
        end else if (dn_req) begin
            if (vel >= vmax)  vel_next = vmax;
            else              vel_next = vel + 5'sd1;
        end else if (vel > 5'sd0) begin
            vel_next = vel - 5'sd1;
        end else if (vel < 5'sd0) begin
            vel_next = vel + 5'sd1;
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle motion: keys (or ball tracking with PADDLE_AI_EN) -> accelerated, clamped Y; rally shrink.
// Latency: one frame from key/hit/serve to registered outputs.
// Backpressure: none; every posedge of frame_clk is a frame.
// Ports: frame_clk, Reset_n (sync, active low), pif (paddle_ctrl_if.slave).
// Build option: define PADDLE_AI_EN to let ai_mode=1 steer the paddle toward BallY.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter logic [9:0] X_POS        = 10'd40,
    parameter logic [9:0] W_HALF       = 10'd4,
    parameter logic [9:0] Y_CENTER     = 10'd240,
    parameter logic [9:0] L_INIT       = 10'd30,
    parameter logic [9:0] L_MIN        = 10'd12,
    parameter logic [9:0] L_STEP       = 10'd6,
    parameter int         SHRINK_EVERY = 4,
    parameter int         MAX_SPEED    = 6,
    parameter int         AI_MAX_SPEED = 4,
    parameter logic [9:0] DEADBAND     = 10'd4,
    parameter int         HOLD_FRAMES  = 60,
    parameter logic [7:0] UP_KEY       = KEY_W,
    parameter logic [7:0] DOWN_KEY     = KEY_S
) (
    input  logic          frame_clk,
    input  logic          Reset_n,
    paddle_ctrl_if.slave  pif
);

    localparam int HC_W = $clog2(HOLD_FRAMES + 1);

    paddle_state_t     state_q, state_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [9:0]        y_q, y_d;
    logic signed [4:0] vel_q, vel_d;
    logic [9:0]        l_q, l_d;
    logic [3:0]        rally_q, rally_d;

    logic              up_req, dn_req;
    logic signed [4:0] vmax;
    logic signed [4:0] vel_step;

    // Source of the accelerate requests: keyboard, or ball tracking when enabled.
    always_comb begin
        up_req = (pif.keycode == UP_KEY);
        dn_req = (pif.keycode == DOWN_KEY);
        vmax   = 5'(MAX_SPEED);
`ifdef PADDLE_AI_EN
        if (pif.ai_mode) begin
            // 11-bit compares so Y-DEADBAND cannot wrap near the top edge
            up_req = ({1'b0, pif.BallY} + {1'b0, DEADBAND}) < {1'b0, y_q};
            dn_req = {1'b0, pif.BallY} > ({1'b0, y_q} + {1'b0, DEADBAND});
            vmax   = 5'(AI_MAX_SPEED);
        end
`endif
    end

`ifndef PADDLE_AI_EN
    // ai_mode/BallY stay on the interface but drive nothing in this build.
    logic unused_ai;
    assign unused_ai = &{1'b0, pif.ai_mode, pif.BallY};
`endif

    paddle_vel_step u_vel_step (
        .vel      (vel_q),
        .up_req   (up_req),
        .dn_req   (dn_req),
        .vmax     (vmax),
        .vel_next (vel_step)
    );

    logic signed [10:0] y_sum, y_lo, y_hi;
    logic [3:0]         rally_inc;
    logic               shrink;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        y_d        = y_q;
        vel_d      = vel_q;
        l_d        = l_q;
        rally_d    = rally_q;

        y_sum     = $signed({1'b0, y_q}) + $signed({{6{vel_step[4]}}, vel_step});
        y_lo      = $signed({1'b0, PF_Y_MIN + l_q});
        y_hi      = $signed({1'b0, PF_Y_MAX - l_q});
        rally_inc = sat15_inc(rally_q);
        shrink    = ((rally_inc % 4'(SHRINK_EVERY)) == 4'd0) &&
                    (rally_inc != 4'd0) && (rally_inc != 4'd15);

        if (pif.serve) begin
            // serve outranks everything, including a same-frame hit
            state_d    = HOLD;
            hold_cnt_d = HC_W'(HOLD_FRAMES);
            y_d        = Y_CENTER;
            vel_d      = '0;
            l_d        = L_INIT;
            rally_d    = '0;
        end else if (state_q == HOLD && hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HC_W'(1);
        end else begin
            // The frame that leaves HOLD (count already 0) is already a play
            // frame, so the first move lands HOLD_FRAMES+1 frames after serve.
            state_d = PLAY;
            if (y_sum < y_lo) begin
                y_d   = y_lo[9:0];
                vel_d = '0;
            end else if (y_sum > y_hi) begin
                y_d   = y_hi[9:0];
                vel_d = '0;
            end else begin
                y_d   = y_sum[9:0];
                vel_d = vel_step;
            end
            // Shrinking only widens the clamp window, so Y needs no fix-up.
            if (pif.hit) begin
                rally_d = rally_inc;
                if (shrink) l_d = (l_q >= L_MIN + L_STEP) ? l_q - L_STEP : L_MIN;
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q    <= HOLD;
            hold_cnt_q <= HC_W'(HOLD_FRAMES);
            y_q        <= Y_CENTER;
            vel_q      <= '0;
            l_q        <= L_INIT;
            rally_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            l_q        <= l_d;
            rally_q    <= rally_d;
        end
    end

    assign pif.PaddleX = X_POS;
    assign pif.PaddleW = W_HALF;
    assign pif.PaddleY = y_q;
    assign pif.PaddleL = l_q;
    assign pif.moving  = (vel_q != 5'sd0);
    assign pif.rally   = rally_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed frames push expected outputs; a monitor pops and compares after each edge.
// Latency: each expectation is checked 1 time unit after the posedge that follows its push.
// Backpressure: n/a.
module tb_paddle_ctrl;
    import pong_pkg::*;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b0;

    paddle_ctrl_if pif ();

    paddle_ctrl dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .pif       (pif)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int         id;
        logic [9:0] y;
        logic [9:0] l;
        logic [3:0] rally;
        logic       moving;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   next_id  = 0;

    // Monitor: one expectation per frame edge, sampled clear of the edge.
    always @(posedge frame_clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (pif.PaddleY !== e.y || pif.PaddleL !== e.l || pif.rally !== e.rally ||
                pif.moving !== e.moving || pif.PaddleX !== 10'd40 || pif.PaddleW !== 10'd4) begin
                failures++;
                $display("FAIL chk%0d: got Y=%0d L=%0d rally=%0d moving=%0d X=%0d W=%0d, want Y=%0d L=%0d rally=%0d moving=%0d X=40 W=4",
                         e.id, pif.PaddleY, pif.PaddleL, pif.rally, pif.moving, pif.PaddleX, pif.PaddleW,
                         e.y, e.l, e.rally, e.moving);
            end
        end
    end

    // Drive one frame's inputs and optionally queue what must show after its edge.
    task automatic step(input logic rn, input logic [7:0] key, input logic s, input logic h,
                        input bit chk, input logic [9:0] y, input logic [9:0] l,
                        input logic [3:0] r, input logic mv);
        exp_t e;
        @(negedge frame_clk);
        Reset_n     = rn;
        pif.keycode = key;
        pif.serve   = s;
        pif.hit     = h;
        if (chk) begin
            e.id = next_id; e.y = y; e.l = l; e.rally = r; e.moving = mv;
            next_id++;
            sb.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at 100000, want finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] ys[$];
        logic [9:0] y;
        logic [9:0] lexp;

        pif.keycode = 8'd0; pif.serve = 1'b0; pif.hit = 1'b0;
        pif.BallY = 10'd100; pif.ai_mode = 1'b0;

        // Reset frame, then UP held through the serve hold.
        step(1'b0, 8'd0, 1'b0, 1'b0, 1, 10'd240, 10'd30, 4'd0, 1'b0);
        for (int i = 0; i < 60; i++)
            step(1'b1, KEY_W, 1'b0, 1'b0, 1, 10'd240, 10'd30, 4'd0, 1'b0);
        step(1'b1, KEY_W, 1'b0, 1'b0, 1, 10'd239, 10'd30, 4'd0, 1'b1);

        // Keep UP: accelerate to -6, then clamp at 20+30.
        ys = '{10'd237, 10'd234, 10'd230, 10'd225, 10'd219};
        foreach (ys[i]) step(1'b1, KEY_W, 1'b0, 1'b0, 1, ys[i], 10'd30, 4'd0, 1'b1);
        y = 10'd219;
        while (y >= 10'd56) begin
            y = y - 10'd6;
            step(1'b1, KEY_W, 1'b0, 1'b0, 1, y, 10'd30, 4'd0, 1'b1);
        end
        step(1'b1, KEY_W, 1'b0, 1'b0, 1, 10'd50, 10'd30, 4'd0, 1'b0);
        step(1'b1, KEY_W, 1'b0, 1'b0, 1, 10'd50, 10'd30, 4'd0, 1'b0);

        // DOWN up to +6, then release and decay (71 -> 86).
        ys = '{10'd51, 10'd53, 10'd56, 10'd60, 10'd65, 10'd71};
        foreach (ys[i]) step(1'b1, KEY_S, 1'b0, 1'b0, 1, ys[i], 10'd30, 4'd0, 1'b1);
        ys = '{10'd76, 10'd80, 10'd83, 10'd85, 10'd86};
        foreach (ys[i]) step(1'b1, 8'd0, 1'b0, 1'b0, 1, ys[i], 10'd30, 4'd0, 1'b1);
        step(1'b1, 8'd0, 1'b0, 1'b0, 1, 10'd86, 10'd30, 4'd0, 1'b0);

        // 16 hits: shrink at 4/8/12, rally saturates at 15.
        for (int i = 1; i <= 16; i++) begin
            lexp = (i < 4) ? 10'd30 : (i < 8) ? 10'd24 : (i < 12) ? 10'd18 : 10'd12;
            step(1'b1, 8'd0, 1'b0, 1'b1, 1, 10'd86, lexp, (i > 15) ? 4'd15 : 4'(i), 1'b0);
        end

        // Serve: back to centre; hits and keys ignored during hold.
        step(1'b1, 8'd0, 1'b1, 1'b0, 1, 10'd240, 10'd30, 4'd0, 1'b0);
        for (int i = 0; i < 60; i++)
            step(1'b1, KEY_S, 1'b0, 1'b1, 1, 10'd240, 10'd30, 4'd0, 1'b0);
        step(1'b1, 8'd0, 1'b0, 1'b0, 1, 10'd240, 10'd30, 4'd0, 1'b0);
        for (int i = 1; i <= 7; i++)
            step(1'b1, 8'd0, 1'b0, 1'b1, 1, 10'd240, (i < 4) ? 10'd30 : 10'd24, 4'(i), 1'b0);

        // Serve and hit together at rally 7, then the full hold reloads.
        step(1'b1, 8'd0, 1'b1, 1'b1, 1, 10'd240, 10'd30, 4'd0, 1'b0);
        for (int i = 0; i < 60; i++)
            step(1'b1, KEY_S, 1'b0, 1'b0, 1, 10'd240, 10'd30, 4'd0, 1'b0);
        step(1'b1, KEY_S, 1'b0, 1'b0, 1, 10'd241, 10'd30, 4'd0, 1'b1);

        // Reset while moving with a hit pending: reset wins.
        step(1'b0, KEY_S, 1'b0, 1'b1, 1, 10'd240, 10'd30, 4'd0, 1'b0);

        pif.ai_mode = 1'b1;
        pif.BallY   = 10'd100;
`ifdef PADDLE_AI_EN
        // AI steers up toward BallY=100 at |v|<=4; DOWN key ignored.
        for (int i = 0; i < 60; i++)
            step(1'b1, KEY_S, 1'b0, 1'b0, 0, 10'd0, 10'd0, 4'd0, 1'b0);
        ys = '{10'd239, 10'd237, 10'd234, 10'd230, 10'd226};
        foreach (ys[i]) step(1'b1, KEY_S, 1'b0, 1'b0, 1, ys[i], 10'd30, 4'd0, 1'b1);
        for (int i = 0; i < 34; i++)
            step(1'b1, KEY_S, 1'b0, 1'b0, 0, 10'd0, 10'd0, 4'd0, 1'b0);
        step(1'b1, KEY_S, 1'b0, 1'b0, 1, 10'd96, 10'd30, 4'd0, 1'b0);
        step(1'b1, KEY_S, 1'b0, 1'b0, 1, 10'd96, 10'd30, 4'd0, 1'b0);
`else
        // Without the AI build, ai_mode has no effect: DOWN key still moves.
        for (int i = 0; i < 60; i++)
            step(1'b1, KEY_S, 1'b0, 1'b0, 0, 10'd0, 10'd0, 4'd0, 1'b0);
        step(1'b1, KEY_S, 1'b0, 1'b0, 1, 10'd241, 10'd30, 4'd0, 1'b1);
        step(1'b1, KEY_S, 1'b0, 1'b0, 1, 10'd243, 10'd30, 4'd0, 1'b1);
`endif

        // Every queued expectation must have been consumed.
        step(1'b1, 8'd0, 1'b0, 1'b0, 0, 10'd0, 10'd0, 4'd0, 1'b0);
        step(1'b1, 8'd0, 1'b0, 1'b0, 0, 10'd0, 10'd0, 4'd0, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
